// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the SRAM data-memory responder.
// Holds the access FSM encoding and the default write-strobe length.
package ram_responder_pkg;

  localparam int unsigned SRAM_DATA_W       = 16;
  localparam int unsigned REQ_ADDR_W        = 16;
  localparam int unsigned WE_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRdSetup  = 3'd1,
    StRdSample = 3'd2,
    StWrSetup  = 3'd3,
    StWrPulse  = 3'd4,
    StWrHold   = 3'd5,
    StDone     = 3'd6
  } state_e;

  // Down-counter preload: the pulse state exits when the counter reads zero.
  function automatic logic [1:0] pulse_load(input int unsigned cycles);
    return 2'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Pipeline-side request/response bundle of the data-memory port.
// The MEM stage is the master; the SRAM responder is the slave.
interface ram_responder_if;
  import ram_responder_pkg::*;

  logic                   MemRead;
  logic                   MemWrite;
  logic [REQ_ADDR_W-1:0]  Address;
  logic [SRAM_DATA_W-1:0] WriteData;
  logic [SRAM_DATA_W-1:0] ReadData;
  logic                   busy;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, busy
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, busy
  );

endinterface

// File: rtl/sram_io.sv
// Tri-state SRAM data pad: drives the bus when enabled and registers the
// bus contents into the read-data register when capture is requested.
module sram_io
  import ram_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drive_en,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   capture,
  output logic [SRAM_DATA_W-1:0] rdata,
  inout  wire  [SRAM_DATA_W-1:0] pad
);

  logic [SRAM_DATA_W-1:0] rdata_q;

  assign pad = drive_en ? wdata : {SRAM_DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= pad;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Data-memory responder: runs MEM-stage reads/writes on an asynchronous
// 16-bit SRAM through a multi-cycle FSM and stalls the pipeline meanwhile.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned WE_CYCLES = WE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_responder_if.slave         bus,
  output logic [ADDR_W-1:0]      sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_data,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  if (WE_CYCLES < 1 || WE_CYCLES > 4) begin : g_bad_we_cycles
    $error("ram_responder: WE_CYCLES must lie in 1..4");
  end

  localparam logic [1:0] CntLoad = pulse_load(WE_CYCLES);

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [REQ_ADDR_W-1:0]  addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   bus_drive;
  logic                   capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Controls decode straight from the state register so an asynchronous
  // reset drops the strobes and releases the bus without a clock edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus.busy  = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    bus_drive = 1'b0;
    capture   = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.busy = bus.MemRead | bus.MemWrite;
        // A write takes priority; a simultaneous read is dropped.
        if (bus.MemWrite) begin
          addr_d  = bus.Address;
          wdata_d = bus.WriteData;
          state_d = StWrSetup;
        end else if (bus.MemRead) begin
          addr_d  = bus.Address;
          state_d = StRdSetup;
        end
      end
      StRdSetup: begin
        bus.busy  = 1'b1;
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        state_d   = StRdSample;
      end
      StRdSample: begin
        bus.busy  = 1'b1;
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        capture   = 1'b1;
        state_d   = StDone;
      end
      StWrSetup: begin
        bus.busy  = 1'b1;
        sram_ce_n = 1'b0;
        bus_drive = 1'b1;
        cnt_d     = CntLoad;
        state_d   = StWrPulse;
      end
      StWrPulse: begin
        bus.busy  = 1'b1;
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        bus_drive = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StWrHold: begin
        bus.busy  = 1'b1;
        sram_ce_n = 1'b0;
        bus_drive = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sram_addr = ADDR_W'(addr_q);

  sram_io u_io (
    .clk      (clk),
    .rst      (rst),
    .drive_en (bus_drive),
    .wdata    (wdata_q),
    .capture  (capture),
    .rdata    (bus.ReadData),
    .pad      (sram_data)
  );

  bus_vs_oe_a : assert property (@(posedge clk) disable iff (!rst)
    !(bus_drive && !sram_oe_n));

  busy_in_access_a : assert property (@(posedge clk) disable iff (!rst)
    (state_q == StIdle) || (state_q == StDone) || bus.busy);

  done_quiet_a : assert property (@(posedge clk) disable iff (!rst)
    (state_q != StDone) || (!bus.busy && sram_ce_n && !bus_drive));

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: behavioural SRAM, word-level memory reference
// model, directed scenarios and a randomized access mix.
module tb_ram_responder;
  import ram_responder_pkg::*;

  localparam int unsigned ADDR_W = 18;
  parameter int unsigned WE_CYCLES = WE_CYCLES_DEFAULT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  wire  [15:0]       sram_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n, sram_oe_n, sram_we_n;

  ram_responder_if bus_if ();

  ram_responder #(
    .ADDR_W    (ADDR_W),
    .WE_CYCLES (WE_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] init_pat(input int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  // Behavioural asynchronous SRAM; unwritten words read as init_pat.
  logic [15:0] mem     [65536];
  bit          written [65536];
  logic [15:0] sram_rd;
  always_comb begin
    sram_rd = written[sram_addr[15:0]] ? mem[sram_addr[15:0]] : init_pat(int'(sram_addr[15:0]));
  end
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_rd : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[15:0]]     <= sram_data;
      written[sram_addr[15:0]] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (dut.bus_drive && !sram_oe_n) begin
        bad++;
        $display("FAIL contention: drive=%b oe_n=%b required oe_n=1 while driving",
                 dut.bus_drive, sram_oe_n);
      end
    end
  end

  // Reference model: word memory plus last completed read.
  logic [15:0] exp_mem [int];
  logic [15:0] exp_last;

  function automatic void predict(input bit wr, input logic [15:0] a, input logic [15:0] d,
                                  output int eb, output int ew, output logic [15:0] er);
    if (wr) begin
      exp_mem[int'(a)] = d;
      eb = 3 + int'(WE_CYCLES);
      ew = int'(WE_CYCLES);
    end else begin
      exp_last = exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_pat(int'(a));
      eb = 3;
      ew = 0;
    end
    er = exp_last;
  endfunction

  typedef struct {
    int                busy_n;
    int                we_low;
    logic [15:0]       rdata;
    logic [ADDR_W-1:0] addr;
    bit                addr_stable;
    logic [2:0]        done_ctrl;
  } obs_t;

  // Drives one request starting in IDLE, holds it through DONE, returns in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, output obs_t o);
    o.busy_n = 0;
    o.we_low = 0;
    o.addr_stable = 1'b1;
    o.addr = '0;
    bus_if.MemRead   = rd;
    bus_if.MemWrite  = wr;
    bus_if.Address   = a;
    bus_if.WriteData = d;
    #1;
    while (bus_if.busy === 1'b1 && o.busy_n < 16) begin
      if (sram_we_n === 1'b0) o.we_low++;
      if (o.busy_n == 1) o.addr = sram_addr;
      else if (o.busy_n > 1 && sram_addr !== o.addr) o.addr_stable = 1'b0;
      o.busy_n++;
      @(posedge clk); #1;
    end
    if (sram_addr !== o.addr) o.addr_stable = 1'b0;
    o.rdata     = bus_if.ReadData;
    o.done_ctrl = {sram_ce_n, sram_oe_n, sram_we_n};
    @(posedge clk); #1;
  endtask

  task automatic clear_req();
    bus_if.MemRead  = 1'b0;
    bus_if.MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0;
    bus_if.Address = '0;   bus_if.WriteData = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    exp_last = 16'h0000;
    total++; if (bus_if.ReadData !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata: got %h want 0000", bus_if.ReadData); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      bad++; $display("FAIL reset_ctrl: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    total++; if (sram_addr !== '0) begin
      bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    total++; if (bus_if.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    total++; if (dut.bus_drive !== 1'b0) begin
      bad++; $display("FAIL reset_bus: drive=%b want 0", dut.bus_drive); end
  endtask

  task automatic test_write_then_read();
    obs_t o; int eb, ew; logic [15:0] er;
    predict(1'b1, 16'h0040, 16'h1234, eb, ew, er);
    access(1'b0, 1'b1, 16'h0040, 16'h1234, o);
    total++; if (o.busy_n != eb) begin
      bad++; $display("FAIL wr_busy: got %0d cycles want %0d", o.busy_n, eb); end
    total++; if (o.we_low != ew) begin
      bad++; $display("FAIL wr_we_low: got %0d cycles want %0d", o.we_low, ew); end
    total++; if (o.rdata !== er) begin
      bad++; $display("FAIL wr_rdata_held: got %h want %h", o.rdata, er); end
    total++; if (o.done_ctrl !== 3'b111) begin
      bad++; $display("FAIL wr_done_ctrl: got %b want 111", o.done_ctrl); end
    predict(1'b0, 16'h0040, 16'h0000, eb, ew, er);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, o);
    total++; if (o.busy_n != eb || o.we_low != ew) begin
      bad++; $display("FAIL rd_timing: got busy=%0d we=%0d want busy=%0d we=%0d",
                      o.busy_n, o.we_low, eb, ew); end
    total++; if (o.rdata !== 16'h1234) begin
      bad++; $display("FAIL rd_data: got %h want 1234", o.rdata); end
    clear_req();
  endtask

  task automatic test_simultaneous();
    obs_t o; int eb, ew; logic [15:0] er;
    predict(1'b1, 16'h0010, 16'hBEEF, eb, ew, er);
    access(1'b1, 1'b1, 16'h0010, 16'hBEEF, o);
    total++; if (o.busy_n != eb || o.we_low != ew) begin
      bad++; $display("FAIL both_timing: got busy=%0d we=%0d want busy=%0d we=%0d",
                      o.busy_n, o.we_low, eb, ew); end
    total++; if (o.rdata !== er) begin
      bad++; $display("FAIL both_rdata_held: got %h want %h", o.rdata, er); end
    predict(1'b0, 16'h0010, 16'h0000, eb, ew, er);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, o);
    total++; if (o.rdata !== er) begin
      bad++; $display("FAIL both_readback: got %h want %h", o.rdata, er); end
    clear_req();
  endtask

  task automatic test_addr_ext();
    obs_t o; int eb, ew; logic [15:0] er;
    logic [ADDR_W-1:0] want;
    logic [15:0] d;
    want = 18'h0FFFF;
    d = 16'($urandom);
    predict(1'b1, 16'hFFFF, d, eb, ew, er);
    access(1'b0, 1'b1, 16'hFFFF, d, o);
    total++; if (o.addr !== want || !o.addr_stable) begin
      bad++; $display("FAIL ext_wr_addr: got %h stable=%0b want %h", o.addr, o.addr_stable, want); end
    predict(1'b0, 16'hFFFF, 16'h0000, eb, ew, er);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, o);
    total++; if (o.addr !== want || !o.addr_stable) begin
      bad++; $display("FAIL ext_rd_addr: got %h stable=%0b want %h", o.addr, o.addr_stable, want); end
    total++; if (o.rdata !== er) begin
      bad++; $display("FAIL ext_rd_data: got %h want %h", o.rdata, er); end
    clear_req();
  endtask

  task automatic test_we_cycles();
    obs_t o; int eb, ew; logic [15:0] er;
    logic [15:0] d;
    d = 16'($urandom);
    predict(1'b1, 16'h0003, d, eb, ew, er);
    access(1'b0, 1'b1, 16'h0003, d, o);
    total++; if (o.we_low != int'(WE_CYCLES)) begin
      bad++; $display("FAIL we_len: got %0d cycles want %0d", o.we_low, WE_CYCLES); end
    predict(1'b0, 16'h0003, 16'h0000, eb, ew, er);
    access(1'b1, 1'b0, 16'h0003, 16'h0000, o);
    total++; if (o.rdata !== d) begin
      bad++; $display("FAIL we_readback: got %h want %h", o.rdata, d); end
    clear_req();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      obs_t o; int eb, ew; logic [15:0] er;
      int op;
      logic [15:0] a, d;
      bit rd, wr;
      op = int'($urandom_range(0, 3));
      a  = 16'h0100 + 16'($urandom_range(0, 15));
      d  = 16'($urandom);
      rd = (op != 2);
      wr = (op >= 2);
      predict(wr, a, d, eb, ew, er);
      access(rd, wr, a, d, o);
      total++; if (o.busy_n != eb || o.we_low != ew || o.done_ctrl !== 3'b111) begin
        bad++; $display("FAIL rnd_timing[%0d]: got busy=%0d we=%0d ctrl=%b want %0d %0d 111",
                        i, o.busy_n, o.we_low, o.done_ctrl, eb, ew); end
      total++; if (o.rdata !== er) begin
        bad++; $display("FAIL rnd_data[%0d]: addr %h got %h want %h", i, a, o.rdata, er); end
      total++; if (o.addr !== ADDR_W'(a) || !o.addr_stable) begin
        bad++; $display("FAIL rnd_addr[%0d]: got %h stable=%0b want %h",
                        i, o.addr, o.addr_stable, ADDR_W'(a)); end
      if ($urandom_range(0, 3) == 0) clear_req();
    end
    clear_req();
  endtask

  task automatic test_reset_mid_write();
    obs_t o; int eb, ew; logic [15:0] er;
    bus_if.MemRead   = 1'b0;
    bus_if.MemWrite  = 1'b1;
    bus_if.Address   = 16'h0777;
    bus_if.WriteData = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (sram_we_n !== 1'b0) begin
      bad++; $display("FAIL mid_pulse_started: we_n=%b want 0", sram_we_n); end
    #2 rst = 1'b0;
    #1;
    total++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      bad++; $display("FAIL mid_async_ctrl: we_n=%b oe_n=%b want 1 1", sram_we_n, sram_oe_n); end
    total++; if (dut.bus_drive !== 1'b0) begin
      bad++; $display("FAIL mid_async_bus: drive=%b want 0", dut.bus_drive); end
    bus_if.MemWrite = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    exp_last = 16'h0000;
    total++; if (bus_if.ReadData !== 16'h0000 || bus_if.busy !== 1'b0) begin
      bad++; $display("FAIL mid_after_reset: rdata=%h busy=%b want 0000 0",
                      bus_if.ReadData, bus_if.busy); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      bad++; $display("FAIL mid_idle_ctrl: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    predict(1'b0, 16'h0040, 16'h0000, eb, ew, er);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, o);
    total++; if (o.rdata !== er || o.busy_n != eb) begin
      bad++; $display("FAIL mid_recover: got %h busy=%0d want %h busy=%0d",
                      o.rdata, o.busy_n, er, eb); end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_simultaneous();
    test_addr_ext();
    test_we_cycles();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Responder end of the pipeline's data-memory port: accepts the MEM stage's read/write requests and carries them out on the board's asynchronous 16-bit SRAM through a multi-cycle access state machine. It sits between the exe/mem pipeline register and the external SRAM pins. While an access is in progress it raises `busy` so the hazard unit can freeze the pipeline. It replaces the single-cycle behavioural data memory in the top level.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM address width; request address is zero-extended to this width.
- `WE_CYCLES`, 2: number of cycles `sram_we_n` is held low per write (valid range 1–4).

Ports:
- `clk` in 1: single system clock. All logic runs on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MemRead` in 1: read request from the MEM stage; held stable while `busy`=1.
- `MemWrite` in 1: write request; held stable while `busy`=1.
- `Address` in 16: word address of the request.
- `WriteData` in 16: data for a write.
- `ReadData` out 16: last completed read value.
- `busy` out 1: stall request to the hazard unit.
- `sram_addr` out ADDR_W: SRAM address pins.
- `sram_data` inout 16: SRAM data pins, tri-stated unless writing.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: SRAM controls, active-low.

## Operation
- States: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - If `MemWrite`=1, latch `Address` and `WriteData` and go to WR_SETUP.
  - Otherwise, if `MemRead`=1, latch `Address` and go to RD_SETUP.
  - If both are asserted, the write wins and the read is dropped.
- Read path:
  - RD_SETUP: `ce_n`=0, `oe_n`=0, bus released.
  - RD_SAMPLE: `ce_n`=0, `oe_n`=0; `sram_data` is registered into `ReadData` at the end of the cycle.
  - Then DONE.
- Write path:
  - WR_SETUP: `ce_n`=0, `we_n`=1, bus driven with the latched data.
  - WR_PULSE: `we_n`=0 for `WE_CYCLES` cycles, counted by a 2-bit down-counter.
  - WR_HOLD: `we_n`=1, bus still driven, `ce_n`=0.
  - Then DONE.
- DONE: controls inactive, bus released, `busy`=0. Always goes to IDLE next cycle, regardless of inputs.
- `busy` is combinational:
  - 1 in IDLE when `MemRead|MemWrite`.
  - 1 in every state other than IDLE and DONE.
  - 0 otherwise.
- `sram_addr` = latched address zero-extended to `ADDR_W`. It is held from the setup state through DONE.
- `ReadData` changes only at the end of RD_SAMPLE and otherwise holds its value. Writes never modify it.
- The bus is never driven while `oe_n`=0; `oe_n` and bus-drive are mutually exclusive in every state.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, `ReadData`=0x0000.
  - `ce_n`=`oe_n`=`we_n`=1, `sram_addr`=0.
  - Bus tri-stated, counter=0.
- Read latency: request seen in IDLE at cycle 0, `busy` high for cycles 0–2, `ReadData` valid and `busy` low in cycle 3 (DONE).
- Write latency: `busy` high for 3+`WE_CYCLES` cycles (IDLE accept, WR_SETUP, pulse cycles, WR_HOLD), then DONE.
- Back-to-back requests: the pipeline advances at the end of DONE. The next request is accepted in the following IDLE cycle, giving one idle cycle between accesses.
- Reset asserted mid-access: the write strobe is aborted immediately. `we_n` and `oe_n` go high and the bus is released in the same cycle the reset is asserted, without waiting for a clock edge.
- Requests that arrive in DONE are ignored; the held request there is the completed one.

## Structure
- The shared package holds:
  - the state enumeration (3-bit encoding),
  - `SRAM_DATA_W`=16,
  - the default for `WE_CYCLES`.
- One natural sub-module, `sram_io`: a 16-bit tri-state data pad with drive-enable and registered input capture.

## Test plan
- Reset mid-write: reset asserted during WR_PULSE -> `we_n`=1 and bus Z asynchronously; after release, state IDLE and `ReadData`=0x0000.
- Write then read: write 0x1234 to 0x0040, then read 0x0040 -> `we_n` low exactly 2 cycles, `ReadData`=0x1234 in the read's DONE cycle, `busy` high 5 then 3 cycles.
- Simultaneous read+write: `MemRead`=`MemWrite`=1, address 0x0010, data 0xBEEF -> only a write occurs; `ReadData` unchanged; a later read of 0x0010 returns 0xBEEF.
- Address extension: `Address`=0xFFFF -> `sram_addr`=0x0FFFF during the access; `ADDR_W`=18 upper bits are 0.
- Bus contention check: a random mix of 200 accesses -> an assertion never sees `oe_n`=0 while the bus is driven, and `busy` is never low in states other than IDLE and DONE.
- `WE_CYCLES`=1 and 4 builds: a write to 0x0003 -> `we_n` low exactly 1 or 4 cycles, and readback matches.
